mult_acc_resp: RTL

Iterative shift-add multiply-accumulate responder: it accepts one operand pair per four-phase request/done handshake from an initiator such as the MAC controller and computes `a*b` over WIDTH cycles. It then either loads or accumulates the product into a 2*WIDTH-bit accumulator and holds `done` until the initiator withdraws the request. It is the serving end of the multiplier handshake used by the accumulation datapath and replaces separate multiplier and adder round trips with a single transaction.

---
 rtl/mult_acc_resp_pkg.sv | 13 +
 rtl/mult_acc_resp_shift_add_step.sv | 19 +
 rtl/mult_acc_resp.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mult_acc_resp_pkg.sv
// Shared types and sizing for the shift-add multiply-accumulate responder.
package mult_acc_resp_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int ACC_W_DEF = 2 * WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_acc_resp_shift_add_step.sv
// One combinational shift-add multiplication iteration.
module shift_add_step
  import mult_acc_resp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] partial_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] partial_o,
  output logic [2*WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0]   mplier_o
);

  assign partial_o = mplier_i[0] ? (partial_i + mcand_i) : partial_i;
  assign mcand_o   = mcand_i << 1;
  assign mplier_o  = mplier_i >> 1;

endmodule

// File: rtl/mult_acc_resp.sv
// Four-phase request/done responder computing a*b iteratively over WIDTH
// cycles, then loading or accumulating the product into a 2*WIDTH-bit register.
module mult_acc_resp
  import mult_acc_resp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               acc,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               ovf
);

  localparam int ACC_W = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [ACC_W-1:0]   partial_q, partial_d;
  logic [ACC_W-1:0]   accum_q, accum_d;
  logic               acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   step_partial;
  logic [ACC_W-1:0]   step_mcand;
  logic [WIDTH-1:0]   step_mplier;
  logic [ACC_W:0]     sum_w;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .partial_i (partial_q),
    .mcand_i   (mcand_q),
    .mplier_i  (mplier_q),
    .partial_o (step_partial),
    .mcand_o   (step_mcand),
    .mplier_o  (step_mplier)
  );

  // Extra top bit captures the carry-out feeding the sticky overflow flag.
  assign sum_w = {1'b0, accum_q} + {1'b0, step_partial};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    accum_d   = accum_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          mcand_d   = {{WIDTH{1'b0}}, a};
          mplier_d  = b;
          acc_d     = acc;
          partial_d = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (!req) begin
          state_d = IDLE;
        end else begin
          partial_d = step_partial;
          mcand_d   = step_mcand;
          mplier_d  = step_mplier;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (acc_q) begin
              accum_d = sum_w[ACC_W-1:0];
              ovf_d   = ovf_q | sum_w[ACC_W];
            end else begin
              accum_d = step_partial;
              ovf_d   = 1'b0;
            end
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      accum_q   <= '0;
      acc_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      accum_q   <= accum_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign result = accum_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q == CALC);
  assign ovf    = ovf_q;

endmodule
